trigger_debouncer: RTL and testbench
====================================

// Module: trigger_debouncer
// PURPOSE
//  Upstream input stage for the bomb controller's 4-bit trigger bus.
//  Synchronises raw push-button inputs to clk and debounces each channel independently.
//  Produces a clean level, a one-cycle press pulse and a one-cycle release pulse per channel.
//  key_pulse drives the controller's trigger input directly.
// PARAMETERS
//  CHANNELS       4          number of independent button channels
//  STABLE_CYCLES  1_000_000  consecutive stable samples to accept a change (20 ms @ 50 MHz); >= 2
//  ACTIVE_LOW     1          1: raw input 0 = pressed (board keys); 0: raw input 1 = pressed
//  CNT_WIDTH      localparam = $clog2(STABLE_CYCLES); not user-settable
// PORTS
//  clk          in   1         system clock, all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  key_raw      in   CHANNELS  asynchronous raw button inputs
//  key_level    out  CHANNELS  debounced state, 1 = pressed
//  key_pulse    out  CHANNELS  1-cycle strobe on accepted press
//  key_release  out  CHANNELS  1-cycle strobe on accepted release
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high; rst sampled high on a posedge
//    -> all outputs 0, FSMs IDLE, counters 0, sync flops = released value.
//  - Polarity: applied at raw input; p = ACTIVE_LOW ? ~key_raw : key_raw.
//    All logic below works on p (1 = pressed).
//  - Synchroniser: 2 flops per channel; s = 2nd stage output.
//  - Per-channel FSM:
//      IDLE:    level=0. s=1 -> SET_CHK, cnt=1.
//      SET_CHK: s=0 -> IDLE, cnt=0 (bounce rejected).
//               s=1 and cnt==STABLE_CYCLES-1 -> PRESSED, pulse=1 for exactly one cycle.
//               otherwise cnt++.
//      PRESSED: level=1. s=0 -> CLR_CHK, cnt=1.
//      CLR_CHK: s=1 -> PRESSED, cnt=0.
//               s=0 and cnt==STABLE_CYCLES-1 -> IDLE, release=1 for exactly one cycle.
//               otherwise cnt++.
//  - Level timing: key_level rises in the same cycle key_pulse is high.
//    key_level falls in the same cycle key_release is high.
//  - Outputs: all registered, no combinational path from key_raw.
//  - Latency: first posedge sampling p=1 is edge 0.
//    Stable press -> key_pulse high in the cycle after edge 1+STABLE_CYCLES.
//    Release has the same latency.
//  - Bounce: any opposite sample before the count completes restarts qualification.
//    No pulse is produced; key_level is unchanged.
//  - Counter: saturates by construction (cleared on state change); never wraps.
//  - Channels: fully independent. Simultaneous qualification on several channels
//    -> their pulse bits assert in the same cycle.
//  - Mid-operation reset: counts and states discarded.
//    A key held through reset is re-qualified from IDLE and yields one fresh key_pulse.
//  - Pulse spacing: at most one key_pulse per channel per press.
//    Minimum pulse spacing is 2*STABLE_CYCLES cycles.
// STRUCTURE
//  - Shared package (bomb_pkg): debounce state encodings DB_IDLE=2'd0, DB_SET_CHK=2'd1,
//    DB_PRESSED=2'd2, DB_CLR_CHK=2'd3; 50 MHz tick constants (TICK_20_MS) alongside
//    the controller's tick and CTRL_* constants.
//  - Sub-module debounce_channel (synchroniser + FSM + counter, 1-bit in, 3 outputs).
//  - Top: polarity inversion and a generate loop of CHANNELS instances.
// TESTING (bench uses STABLE_CYCLES=4, ACTIVE_LOW=1)
//  1. Reset hold: rst=1 for 3 cycles, key_raw=4'b1111 -> all outputs 0 throughout;
//     no pulse in the cycle after rst falls.
//  2. Clean press: key_raw[0] 1->0 and held -> key_pulse=4'b0001 for exactly 1 cycle,
//     6 cycles after the first sampling edge; key_level[0]=1 from that cycle on.
//  3. Bounce: key_raw[1] pattern 0,1,0,1,0 (1 cycle each), then held 0
//     -> single key_pulse[1], counted from the last 1->0 edge; no earlier strobe.
//  4. Release: from test 2, key_raw[0]=1 held -> key_release=4'b0001 for 1 cycle
//     after the same latency; key_level[0]=0; a 2-cycle glitch back to 0 first
//     -> no release.
//  5. Simultaneous: key_raw 1111->0000 on one edge -> key_pulse=4'b1111 in one cycle,
//     then 4'b0000.
//  6. Reset mid-qualify: rst pulsed 1 cycle while channel 2 is in SET_CHK, key held
//     -> exactly one key_pulse[2], 6 cycles after the first post-reset edge.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb controller: debounce state encodings
// and 50 MHz tick constants used by the input stage and the controller.
package bomb_pkg;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_SET_CHK = 2'd1,
    DB_PRESSED = 2'd2,
    DB_CLR_CHK = 2'd3
  } db_state_e;

  localparam int CLK_HZ     = 50_000_000;
  localparam int TICK_1_MS  = CLK_HZ / 1_000;
  localparam int TICK_20_MS = 20 * TICK_1_MS;
  localparam int TICK_1_S   = CLK_HZ;

  localparam int CTRL_TRIGGERS      = 4;
  localparam int CTRL_TIMER_WIDTH   = 8;
  localparam int CTRL_TIMER_DEFAULT = 30;

endpackage : bomb_pkg

// File: rtl/debounce_channel.sv
// One debounced button channel: 2-flop synchroniser, qualification counter
// and a four-state FSM producing a level plus press/release strobes.
module debounce_channel
  import bomb_pkg::*;
#(
  parameter int STABLE_CYCLES = TICK_20_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_level,
  output logic o_pulse,
  output logic o_release
);

  localparam int                  CNT_WIDTH = $clog2(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 r_sync1, r_sync2;
  db_state_e            r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_pulse, r_release;
  logic                 w_pulse_nxt, w_release_nxt;
  logic                 w_done;

  assign w_done = (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= DB_IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_key;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_release <= w_release_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      DB_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = DB_SET_CHK;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      DB_SET_CHK: begin
        if (!r_sync2) begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = DB_PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DB_PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = DB_CLR_CHK;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      DB_CLR_CHK: begin
        if (r_sync2) begin
          w_state_nxt = DB_PRESSED;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt   = DB_IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = DB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level is a decode of the state register, so it flips on the strobe edge.
  always_comb begin
    o_level   = (r_state == DB_PRESSED) || (r_state == DB_CLR_CHK);
    o_pulse   = r_pulse;
    o_release = r_release;
  end

endmodule : debounce_channel

// File: rtl/trigger_debouncer.sv
// Input stage for the bomb controller's trigger bus: polarity correction
// followed by an independent debounce channel per raw button.
module trigger_debouncer
  import bomb_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = TICK_20_MS,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key_raw,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_pulse,
  output logic [CHANNELS-1:0] key_release
);

  logic [CHANNELS-1:0] w_key_p;

  generate
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("trigger_debouncer: STABLE_CYCLES must be at least 2");
    end
  endgenerate

  assign w_key_p = ACTIVE_LOW ? ~key_raw : key_raw;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .i_key    (w_key_p[g]),
      .o_level  (key_level[g]),
      .o_pulse  (key_pulse[g]),
      .o_release(key_release[g])
    );
  end

endmodule : trigger_debouncer

// File: tb/tb_trigger_debouncer.sv
// Directed bench for trigger_debouncer with STABLE_CYCLES=4, active-low keys.
module tb_trigger_debouncer;

  localparam int CH = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] key_raw;
  logic [CH-1:0] key_level;
  logic [CH-1:0] key_pulse;
  logic [CH-1:0] key_release;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trigger_debouncer #(
    .CHANNELS     (CH),
    .STABLE_CYCLES(SC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_pulse  (key_pulse),
    .key_release(key_release)
  );

  // Outputs are sampled 1 ns after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    key_raw = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({key_level, key_pulse, key_release} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got lvl=%b pls=%b rel=%b, want all 0",
                 i, key_level, key_pulse, key_release);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({key_level, key_pulse, key_release} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_release: got lvl=%b pls=%b rel=%b, want all 0",
               key_level, key_pulse, key_release);
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_lvl, exp_pls;
    key_raw = 4'b1110;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_pls = (k == 5) ? 4'b0001 : 4'b0000;
      exp_lvl = (k >= 5) ? 4'b0001 : 4'b0000;
      n_checks++;
      if ({key_level, key_pulse, key_release} !== {exp_lvl, exp_pls, 4'b0000}) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got lvl=%b pls=%b rel=%b, want lvl=%b pls=%b rel=0000",
                 k, key_level, key_pulse, key_release, exp_lvl, exp_pls);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat [4] = '{4'b1100, 4'b1110, 4'b1100, 4'b1110};
    logic [3:0] exp_lvl, exp_pls;
    for (int k = 0; k <= 10; k++) begin
      key_raw = (k < 4) ? pat[k] : 4'b1100;
      tick();
      exp_pls = (k == 9) ? 4'b0010 : 4'b0000;
      exp_lvl = (k >= 9) ? 4'b0011 : 4'b0001;
      n_checks++;
      if ({key_level, key_pulse, key_release} !== {exp_lvl, exp_pls, 4'b0000}) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got lvl=%b pls=%b rel=%b, want lvl=%b pls=%b rel=0000",
                 k, key_level, key_pulse, key_release, exp_lvl, exp_pls);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] exp_lvl, exp_rel;
    for (int k = 0; k <= 7; k++) begin
      key_raw = (k < 2) ? 4'b1101 : 4'b1100;
      tick();
      n_checks++;
      if ({key_level, key_pulse, key_release} !== {4'b0011, 4'b0000, 4'b0000}) begin
        n_fail++;
        $display("FAIL release_glitch edge %0d: got lvl=%b pls=%b rel=%b, want lvl=0011 pls=0000 rel=0000",
                 k, key_level, key_pulse, key_release);
      end
    end
    key_raw = 4'b1101;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_rel = (k == 5) ? 4'b0001 : 4'b0000;
      exp_lvl = (k >= 5) ? 4'b0010 : 4'b0011;
      n_checks++;
      if ({key_level, key_pulse, key_release} !== {exp_lvl, 4'b0000, exp_rel}) begin
        n_fail++;
        $display("FAIL release edge %0d: got lvl=%b pls=%b rel=%b, want lvl=%b pls=0000 rel=%b",
                 k, key_level, key_pulse, key_release, exp_lvl, exp_rel);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_lvl, exp_pls, exp_rel;
    key_raw = 4'hF;
    repeat (10) tick();
    n_checks++;
    if ({key_level, key_pulse, key_release} !== 12'h000) begin
      n_fail++;
      $display("FAIL simul_idle: got lvl=%b pls=%b rel=%b, want all 0",
               key_level, key_pulse, key_release);
    end
    key_raw = 4'h0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_pls = (k == 5) ? 4'b1111 : 4'b0000;
      exp_lvl = (k >= 5) ? 4'b1111 : 4'b0000;
      n_checks++;
      if ({key_level, key_pulse, key_release} !== {exp_lvl, exp_pls, 4'b0000}) begin
        n_fail++;
        $display("FAIL simul_press edge %0d: got lvl=%b pls=%b rel=%b, want lvl=%b pls=%b rel=0000",
                 k, key_level, key_pulse, key_release, exp_lvl, exp_pls);
      end
    end
    key_raw = 4'hF;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_rel = (k == 5) ? 4'b1111 : 4'b0000;
      exp_lvl = (k >= 5) ? 4'b0000 : 4'b1111;
      n_checks++;
      if ({key_level, key_pulse, key_release} !== {exp_lvl, 4'b0000, exp_rel}) begin
        n_fail++;
        $display("FAIL simul_release edge %0d: got lvl=%b pls=%b rel=%b, want lvl=%b pls=0000 rel=%b",
                 k, key_level, key_pulse, key_release, exp_lvl, exp_rel);
      end
    end
  endtask

  task automatic test_reset_mid_qualify();
    logic [3:0] exp_lvl, exp_pls;
    key_raw = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({key_level, key_pulse, key_release} !== 12'h000) begin
        n_fail++;
        $display("FAIL midrst_pre edge %0d: got lvl=%b pls=%b rel=%b, want all 0",
                 k, key_level, key_pulse, key_release);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({key_level, key_pulse, key_release} !== 12'h000) begin
      n_fail++;
      $display("FAIL midrst_reset: got lvl=%b pls=%b rel=%b, want all 0",
               key_level, key_pulse, key_release);
    end
    for (int k = 0; k <= 8; k++) begin
      tick();
      exp_pls = (k == 5) ? 4'b0100 : 4'b0000;
      exp_lvl = (k >= 5) ? 4'b0100 : 4'b0000;
      n_checks++;
      if ({key_level, key_pulse, key_release} !== {exp_lvl, exp_pls, 4'b0000}) begin
        n_fail++;
        $display("FAIL midrst_press edge %0d: got lvl=%b pls=%b rel=%b, want lvl=%b pls=%b rel=0000",
                 k, key_level, key_pulse, key_release, exp_lvl, exp_pls);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    key_raw = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_qualify();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_trigger_debouncer
